al4s3b_wb_master: RTL and testbench

//  Single-outstanding Wishbone initiator: turns a valid/ready command stream into one classic WB cycle
//  (CYC/STB held until ACK) and returns the result on a valid/ready response stream. It drives the
//  WBs_* slave port of the FPGA IP top (FPGA regs, UART0/1, QL reserved) from fabric logic or a

---
 rtl/al4s3b_wb_master.sv | 168 ++++++++++++++++
 tb/tb_al4s3b_wb_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/al4s3b_wb_master.sv
// Single-outstanding Wishbone initiator: valid/ready command in, one classic WB cycle, valid/ready response out.
// Optional ACK timeout watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module al4s3b_wb_master #(
    parameter int                      ADDRWIDTH          = 17,
    parameter int                      DATAWIDTH          = 32,
    parameter int                      TIMEOUT_CNTR_WIDTH = 8,
    parameter int                      TIMEOUT_CYCLES     = 255,
    parameter logic [DATAWIDTH-1:0]    TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [ADDRWIDTH-1:0]     cmd_adr_i,
    input  logic [DATAWIDTH/8-1:0]   cmd_byte_stb_i,
    input  logic [DATAWIDTH-1:0]     cmd_dat_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATAWIDTH-1:0]     rsp_dat_o,
    output logic                     rsp_err_o,
    output logic [ADDRWIDTH-1:0]     WBs_ADR_o,
    output logic [DATAWIDTH/8-1:0]   WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]     WBs_WR_DAT_o,
    output logic                     WBs_CYC_o,
    output logic                     WBs_STB_o,
    output logic                     WBs_WE_o,
    output logic                     WBs_RD_o,
    input  logic [DATAWIDTH-1:0]     WBs_RD_DAT_i,
    input  logic                     WBs_ACK_i,
    output logic                     busy_o
);

    localparam int STBW = DATAWIDTH / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TIMEOUT_CNTR_WIDTH) - 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must fit in TIMEOUT_CNTR_WIDTH bits and be nonzero");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_tmo_hit;
    logic [DATAWIDTH-1:0]   w_rsp_dat;

    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic [DATAWIDTH-1:0]   r_rsp_dat;
    logic                   r_rsp_err;
    logic [ADDRWIDTH-1:0]   r_adr;
    logic [STBW-1:0]        r_byte_stb;
    logic [DATAWIDTH-1:0]   r_wr_dat;
    logic                   r_cyc;
    logic                   r_we;
    logic                   r_rd;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] TMO_LAST = TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNTR_WIDTH-1:0] r_tmo;

    // Counter holds (BUS cycle number - 1); expiry fires on the last permitted BUS cycle.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i || w_accept)
            r_tmo <= '0;
        else if (r_state == S_BUS)
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo_hit = (r_state == S_BUS) && !WBs_ACK_i && (r_tmo == TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_rsp_dat = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_BUS;
                end
            end
            S_BUS: begin
                // ACK takes priority over a simultaneous timeout expiry.
                if (WBs_ACK_i) begin
                    w_done    = 1'b1;
                    w_rsp_dat = r_we ? '0 : WBs_RD_DAT_i;
                    w_next    = S_RESP;
                end else if (w_tmo_hit) begin
                    w_done    = 1'b1;
                    w_rsp_dat = TIMEOUT_READ_VALUE;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_adr       <= '0;
            r_byte_stb  <= '0;
            r_wr_dat    <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_rd        <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_cyc      <= 1'b1;
                r_we       <= cmd_we_i;
                r_rd       <= !cmd_we_i;
                r_adr      <= cmd_adr_i;
                r_byte_stb <= cmd_we_i ? cmd_byte_stb_i : {STBW{1'b1}};
                r_wr_dat   <= cmd_dat_i;
            end
            if (w_done) begin
                r_cyc       <= 1'b0;
                r_we        <= 1'b0;
                r_rd        <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_dat   <= w_rsp_dat;
                r_rsp_err   <= w_tmo_hit && !WBs_ACK_i;
            end
            if (r_state == S_RESP && rsp_ready_i)
                r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready_o    = r_cmd_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_dat_o      = r_rsp_dat;
`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_err_o      = r_rsp_err;
`else
    assign rsp_err_o      = 1'b0;
`endif
    assign WBs_ADR_o      = r_adr;
    assign WBs_BYTE_STB_o = r_byte_stb;
    assign WBs_WR_DAT_o   = r_wr_dat;
    assign WBs_CYC_o      = r_cyc;
    assign WBs_STB_o      = r_cyc;
    assign WBs_WE_o       = r_we;
    assign WBs_RD_o       = r_rd;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_al4s3b_wb_master.sv
// Directed bench for al4s3b_wb_master: vector table of single transactions plus hand-written corner sequences.
module tb_al4s3b_wb_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [16:0] cmd_adr;
    logic [3:0]  cmd_stb;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [16:0] wb_adr;
    logic [3:0]  wb_stb;
    logic [31:0] wb_wdat, wb_rdat;
    logic        wb_cyc, wb_stb_o, wb_we, wb_rd, wb_ack, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    al4s3b_wb_master dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_byte_stb_i(cmd_stb), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .WBs_ADR_o(wb_adr), .WBs_BYTE_STB_o(wb_stb), .WBs_WR_DAT_o(wb_wdat),
        .WBs_CYC_o(wb_cyc), .WBs_STB_o(wb_stb_o), .WBs_WE_o(wb_we), .WBs_RD_o(wb_rd),
        .WBs_RD_DAT_i(wb_rdat), .WBs_ACK_i(wb_ack), .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [3:0]  stb;
        logic [31:0] dat;
        int          cyc;       // CYC-high cycles before ACK completes
        logic [31:0] rdat;
        logic [3:0]  exp_stb;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_stb   = v.stb;
        cmd_dat   = v.dat;
    endtask

    // Drives one command from IDLE, acks it, and leaves the DUT in RESP (response not consumed).
    task automatic run_bus(input vec_t v);
        drive_cmd(v);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i <= v.cyc; i++) begin
            chk("bus_ctrl", {28'd0, wb_cyc, wb_stb_o, wb_we, wb_rd}, {28'd0, 1'b1, 1'b1, v.we, ~v.we});
            chk("bus_adr", {15'd0, wb_adr}, {15'd0, v.adr});
            chk("bus_bstb", {28'd0, wb_stb}, {28'd0, v.exp_stb});
            chk("bus_wdat", wb_wdat, v.dat);
            chk("bus_cmd_ready", {30'd0, cmd_ready, busy}, 32'd1);
            if (i == v.cyc) begin
                wb_ack  = 1'b1;
                wb_rdat = v.rdat;
            end
            step();
            wb_ack  = 1'b0;
            wb_rdat = 32'hDEAD_BEEF;
        end
        chk("rsp_ctrl", {28'd0, wb_cyc, wb_stb_o, wb_we, wb_rd}, 32'd0);
        chk("rsp_valid", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("rsp_dat", rsp_dat, v.exp_rsp);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("consumed", {29'd0, rsp_valid, cmd_ready, busy}, 32'd2);
    endtask

    initial begin
        int bad;
        vec_t v;
        tbl[0] = '{1'b1, 17'h01000, 4'b0001, 32'h0000_0055, 3, 32'hDEAD_BEEF, 4'b0001, 32'h0};
        tbl[1] = '{1'b0, 17'h01014, 4'b0000, 32'h0,         1, 32'h0000_0060, 4'hF,    32'h0000_0060};
        tbl[2] = '{1'b1, 17'h1FFFC, 4'b1100, 32'hFFFF_FFFF, 2, 32'h1234_5678, 4'b1100, 32'h0};
        tbl[3] = '{1'b0, 17'h00000, 4'b0101, 32'h0,         4, 32'hA5A5_5A5A, 4'hF,    32'hA5A5_5A5A};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_stb = '0; cmd_dat = '0;
        rsp_ready = 1'b0; wb_rdat = 32'hDEAD_BEEF; wb_ack = 1'b0;
        repeat (3) step();
        chk("reset_ctrl", {24'd0, cmd_ready, rsp_valid, rsp_err, wb_cyc, wb_stb_o, wb_we, wb_rd, busy}, 32'd0);
        chk("reset_bus", {wb_stb, 11'd0, wb_adr} | wb_wdat | rsp_dat, 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_ready", {31'd0, cmd_ready}, 32'd1);

        // Table of independent transactions, each consumed immediately.
        for (int k = 0; k < 4; k++) begin
            run_bus(tbl[k]);
            consume();
        end

        // Response back-pressure with a queued command.
        run_bus(tbl[1]);
        v = tbl[0];
        drive_cmd(v);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_rsp", {29'd0, rsp_valid, cmd_ready, wb_cyc}, 32'd4);
            chk("hold_dat", rsp_dat, 32'h60);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_release", {29'd0, rsp_valid, cmd_ready, wb_cyc}, 32'd2);
        step();
        cmd_valid = 1'b0;
        chk("queued_start", {14'd0, wb_cyc, wb_we, wb_adr}, {14'd0, 1'b1, 1'b1, 17'h01000});
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        consume();

        // Reset in the middle of a bus cycle.
        drive_cmd(tbl[3]);
        step();
        cmd_valid = 1'b0;
        step();
        chk("pre_rst_cyc", {31'd0, wb_cyc}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_ctrl", {26'd0, cmd_ready, rsp_valid, wb_cyc, wb_stb_o, wb_rd, busy}, 32'd0);
        chk("midrst_adr", {15'd0, wb_adr}, 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_norsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        run_bus(tbl[2]);

        // Stray ACK while in RESP, then in IDLE.
        wb_ack = 1'b1; wb_rdat = 32'h7777_7777;
        step();
        wb_ack = 1'b0;
        chk("stray_resp", {29'd0, rsp_valid, wb_cyc, cmd_ready}, 32'd4);
        chk("stray_resp_dat", rsp_dat, 32'h0);
        consume();
        wb_ack = 1'b1;
        step();
        step();
        wb_ack = 1'b0;
        chk("stray_idle", {28'd0, rsp_valid, wb_cyc, busy, cmd_ready}, 32'd1);

        // Back-to-back commands against a zero-wait slave.
        rsp_ready = 1'b1;
        wb_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00100 + 17'(k * 4);
            wb_rdat = 32'h100 + 32'(k);
            chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
            step();
            cmd_valid = 1'b0;
            chk("b2b_bus", {14'd0, wb_cyc, rsp_valid, wb_adr}, {14'd0, 2'b10, 17'h00100 + 17'(k * 4)});
            step();
            chk("b2b_rsp", {30'd0, wb_cyc, rsp_valid}, 32'd1);
            chk("b2b_dat", rsp_dat, 32'h100 + 32'(k));
            step();
        end
        wb_ack = 1'b0;
        rsp_ready = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
        // Timeout: no ACK, then ACK exactly on the last permitted cycle.
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h04000;
            step();
            cmd_valid = 1'b0;
            n = 0;
            while (wb_cyc && n < 400) begin
                n++;
                if (pass == 1 && n == 255) begin
                    wb_ack = 1'b1; wb_rdat = 32'h0000_0077;
                end
                step();
                wb_ack = 1'b0;
            end
            chk("tmo_cyc_len", 32'(n), 32'd255);
            chk("tmo_valid", {31'd0, rsp_valid}, 32'd1);
            chk("tmo_err", {31'd0, rsp_err}, (pass == 0) ? 32'd1 : 32'd0);
            chk("tmo_dat", rsp_dat, (pass == 0) ? 32'hBADF_ABAC : 32'h0000_0077);
            consume();
        end
`else
        // Without the watchdog the cycle waits indefinitely for ACK.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h04000;
        step();
        cmd_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (!wb_cyc || rsp_valid) bad++;
            step();
        end
        chk("no_tmo_wait", 32'(bad), 32'd0);
        wb_ack = 1'b1; wb_rdat = 32'h0000_0077;
        step();
        wb_ack = 1'b0;
        chk("no_tmo_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("no_tmo_dat", rsp_dat, 32'h0000_0077);
        consume();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
